column_dropper: RTL and testbench

COLUMN_DROPPER -- requirements
Module: column_dropper

---
 rtl/column_dropper.sv | 125 ++++++++++++
 tb/tb_column_dropper.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_dropper.sv
// rtl/column_dropper.sv - gravity-drop game board controller (optional undo via COLUMN_DROPPER_UNDO_EN)
module column_dropper #(
    parameter int ROWS  = 6,
    parameter int COLS  = 7,
    parameter int COL_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [COL_W-1:0]       in_column,
    input  logic [1:0]             state,
    input  logic                   in_undo,
    output logic                   out_ready,
    output logic                   out_done,
    output logic                   out_err,
    output logic [2:0]             out_row,
    output logic [ROWS*COLS-1:0]   out_gameboard,
    output logic [ROWS*COLS-1:0]   out_players_cells,
    output logic                   out_board_full
);

    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE, ERROR} fsm_t;

    fsm_t             fsm_state;
    logic [COL_W-1:0] col_q;
    logic             p2_q;
    logic [ROW_W-1:0] row_idx;
    logic [IDX_W-1:0] cell_idx;
    logic             req_legal;

    // A request is legal only for an on-board column and a real player code
    assign req_legal = (int'(in_column) < COLS) && ((state == 2'b01) || (state == 2'b10));

    // Flat board index of the cell currently being probed
    assign cell_idx = IDX_W'(int'(row_idx) * COLS + int'(col_q));

    assign out_ready      = (fsm_state == IDLE);
    assign out_board_full = &out_gameboard;

`ifdef COLUMN_DROPPER_UNDO_EN
    logic             undo_valid;
    logic [IDX_W-1:0] undo_idx;
`else
    logic unused_undo;
    assign unused_undo = in_undo;
`endif

    // Control FSM: accept, bottom-up scan, one-cycle result pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_state         <= IDLE;
            col_q             <= '0;
            p2_q              <= 1'b0;
            row_idx           <= '0;
            out_done          <= 1'b0;
            out_err           <= 1'b0;
            out_row           <= 3'd0;
            out_gameboard     <= '0;
            out_players_cells <= '0;
`ifdef COLUMN_DROPPER_UNDO_EN
            undo_valid        <= 1'b0;
            undo_idx          <= '0;
`endif
        end else begin
            out_done <= 1'b0;
            out_err  <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (in_valid) begin
                        if (req_legal) begin
                            col_q     <= in_column;
                            p2_q      <= (state == 2'b10);
                            row_idx   <= '0;
                            fsm_state <= SCAN;
                        end else begin
                            fsm_state <= ERROR;
                        end
                    end
`ifdef COLUMN_DROPPER_UNDO_EN
                    else if (in_undo) begin
                        if (undo_valid) begin
                            out_gameboard[undo_idx]     <= 1'b0;
                            out_players_cells[undo_idx] <= 1'b0;
                            undo_valid                  <= 1'b0;
                            fsm_state                   <= DONE;
                        end else begin
                            fsm_state <= ERROR;
                        end
                    end
`endif
                end
                SCAN: begin
                    if (!out_gameboard[cell_idx]) begin
                        out_gameboard[cell_idx]     <= 1'b1;
                        out_players_cells[cell_idx] <= p2_q;
                        out_row                     <= 3'(row_idx);
`ifdef COLUMN_DROPPER_UNDO_EN
                        undo_valid                  <= 1'b1;
                        undo_idx                    <= cell_idx;
`endif
                        fsm_state                   <= DONE;
                    end else if (int'(row_idx) == ROWS - 1) begin
                        fsm_state <= ERROR;
                    end else begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                DONE: begin
                    out_done  <= 1'b1;
                    fsm_state <= IDLE;
                end
                ERROR: begin
                    out_err   <= 1'b1;
                    fsm_state <= IDLE;
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_dropper.sv
// tb/tb_column_dropper.sv - self-checking bench for column_dropper
module tb_column_dropper;

    localparam int R = 6;
    localparam int C = 7;
    localparam int CELLS = R * C;
    localparam int BR = 4;
    localparam int BC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid;
    logic [2:0]       in_column;
    logic [1:0]       state;
    logic             in_undo;
    logic             out_ready;
    logic             out_done;
    logic             out_err;
    logic [2:0]       out_row;
    logic [CELLS-1:0] out_gameboard;
    logic [CELLS-1:0] out_players_cells;
    logic             out_board_full;

    logic             b_valid;
    logic [2:0]       b_column;
    logic [1:0]       b_state;
    logic             b_undo;
    logic             b_ready;
    logic             b_done;
    logic             b_err;
    logic [2:0]       b_row;
    logic [BR*BC-1:0] b_board;
    logic [BR*BC-1:0] b_cells;
    logic             b_full;

    column_dropper #(.ROWS(R), .COLS(C), .COL_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_column(in_column),
        .state(state), .in_undo(in_undo), .out_ready(out_ready), .out_done(out_done),
        .out_err(out_err), .out_row(out_row), .out_gameboard(out_gameboard),
        .out_players_cells(out_players_cells), .out_board_full(out_board_full)
    );

    column_dropper #(.ROWS(BR), .COLS(BC), .COL_W(3)) dut_small (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_column(b_column),
        .state(b_state), .in_undo(b_undo), .out_ready(b_ready), .out_done(b_done),
        .out_err(b_err), .out_row(b_row), .out_gameboard(b_board),
        .out_players_cells(b_cells), .out_board_full(b_full)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: 2-D board, column heights, single-move undo record
    bit occ[R][C];
    bit own[R][C];
    int height[C];
    bit rec_valid;
    int rec_r;
    int rec_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CELLS-1:0] exp_board();
        logic [CELLS-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                v[r*C+c] = occ[r][c];
        return v;
    endfunction

    function automatic logic [CELLS-1:0] exp_cells();
        logic [CELLS-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                v[r*C+c] = own[r][c];
        return v;
    endfunction

    function automatic bit model_full();
        bit f;
        f = 1'b1;
        for (int c = 0; c < C; c++)
            if (height[c] != R) f = 1'b0;
        return f;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                occ[r][c] = 1'b0;
                own[r][c] = 1'b0;
            end
        for (int c = 0; c < C; c++) height[c] = 0;
        rec_valid = 1'b0;
        rec_r = 0;
        rec_c = 0;
    endtask

    task automatic check_board(input string tag);
        check({tag, " board"}, 64'(out_gameboard), 64'(exp_board()));
        check({tag, " cells"}, 64'(out_players_cells), 64'(exp_cells()));
        check({tag, " full"}, 64'(out_board_full), 64'(model_full()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        in_undo = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic scramble();
        in_valid  = 1'($urandom);
        in_column = 3'($urandom);
        state     = 2'($urandom);
        in_undo   = 1'($urandom);
    endtask

    task automatic do_move(input int col, input int st, input bit with_undo, input string tag);
        bit legal;
        bit exp_done;
        int exp_row;
        int lat;
        int k;
        bit got_done;
        bit got_err;
        legal = (col < C) && (st == 1 || st == 2);
        exp_row = 0;
        if (!legal) begin
            exp_done = 1'b0;
            lat = 1;
        end else if (height[col] < R) begin
            exp_done = 1'b1;
            exp_row = height[col];
            lat = exp_row + 2;
        end else begin
            exp_done = 1'b0;
            lat = R + 1;
        end
        @(negedge clk);
        check({tag, " ready"}, 64'(out_ready), 64'd1);
        in_valid  = 1'b1;
        in_column = col[2:0];
        state     = st[1:0];
        in_undo   = with_undo;
        @(posedge clk);
        #1;
        scramble();
        k = 0;
        got_done = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (out_done || out_err) begin
                got_done = out_done;
                got_err = out_err;
                break;
            end
            scramble();
        end
        in_valid = 1'b0;
        in_undo = 1'b0;
        check({tag, " latency"}, 64'(k), 64'(lat));
        check({tag, " done"}, 64'(got_done), 64'(exp_done));
        check({tag, " err"}, 64'(got_err), 64'(!exp_done));
        if (exp_done) begin
            occ[exp_row][col] = 1'b1;
            own[exp_row][col] = (st == 2);
            height[col]++;
            rec_valid = 1'b1;
            rec_r = exp_row;
            rec_c = col;
            check({tag, " row"}, 64'(out_row), 64'(exp_row));
        end
        check_board(tag);
        @(posedge clk);
        #1;
        check({tag, " pulse cleared"}, 64'({out_done, out_err}), 64'd0);
    endtask

    task automatic do_undo(input string tag);
        int k;
        bit got_done;
        bit got_err;
        @(negedge clk);
        in_valid = 1'b0;
        in_undo = 1'b1;
        @(posedge clk);
        #1;
        in_undo = 1'b0;
        k = 0;
        got_done = 1'b0;
        got_err = 1'b0;
`ifdef COLUMN_DROPPER_UNDO_EN
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (out_done || out_err) begin
                got_done = out_done;
                got_err = out_err;
                break;
            end
        end
        check({tag, " latency"}, 64'(k), 64'd1);
        check({tag, " done"}, 64'(got_done), 64'(rec_valid));
        check({tag, " err"}, 64'(got_err), 64'(!rec_valid));
        if (rec_valid) begin
            occ[rec_r][rec_c] = 1'b0;
            own[rec_r][rec_c] = 1'b0;
            height[rec_c]--;
            rec_valid = 1'b0;
        end
`else
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (out_done || out_err || !out_ready) begin
                got_done = 1'b1;
                break;
            end
        end
        check({tag, " ignored"}, 64'({got_done, got_err}), 64'd0);
`endif
        check_board(tag);
    endtask

    task automatic b_move(input int col, input int st, output bit done, output bit err, output int lat);
        @(negedge clk);
        b_valid  = 1'b1;
        b_column = col[2:0];
        b_state  = st[1:0];
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        lat = 0;
        done = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b_done || b_err) begin
                done = b_done;
                err = b_err;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bd;
        bit be;
        int bl;
        logic [BR*BC-1:0] b_exp_board;
        logic [BR*BC-1:0] b_exp_cells;
        int pst;

        reset = 1'b0;
        in_valid = 1'b0;
        in_column = '0;
        state = '0;
        in_undo = 1'b0;
        b_valid = 1'b0;
        b_column = '0;
        b_state = '0;
        b_undo = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset ready", 64'(out_ready), 64'd1);
        check("reset done", 64'(out_done), 64'd0);
        check("reset err", 64'(out_err), 64'd0);
        check("reset row", 64'(out_row), 64'd0);
        check_board("reset");

        do_move(0, 1, 1'b0, "first move");
        check("first move bit0", 64'(out_gameboard[0]), 64'd1);
        check("first move owner0", 64'(out_players_cells[0]), 64'd0);

        do_reset();
        do_move(0, 1, 1'b0, "seq m1");
        do_move(2, 2, 1'b0, "seq m2");
        do_move(0, 1, 1'b0, "seq m3");
        do_move(2, 2, 1'b0, "seq m4");
        check("seq bits", 64'(out_gameboard[9:0]), 64'h285);
        check("seq owners", 64'(out_players_cells[9:0]), 64'h204);

        for (int i = 0; i < R; i++) do_move(6, (i % 2) + 1, 1'b0, "fill col6");
        do_move(6, 1, 1'b0, "col6 full");

        do_move(7, 1, 1'b0, "bad column");
        do_move(1, 3, 1'b0, "bad player");
        do_move(1, 0, 1'b0, "bad player0");

        do_reset();
        do_move(3, 2, 1'b0, "undo setup");
        do_undo("undo first");
        do_undo("undo second");
        do_move(3, 1, 1'b1, "move with undo");
        do_undo("undo after combo");

        for (int i = 0; i < 3; i++) do_move(4, 1, 1'b0, "prefill col4");
        @(negedge clk);
        in_valid = 1'b1;
        in_column = 3'd4;
        state = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        check("midscan reset ready", 64'(out_ready), 64'd1);
        check("midscan reset row", 64'(out_row), 64'd0);
        check("midscan reset pulses", 64'({out_done, out_err}), 64'd0);
        check_board("midscan reset");
        @(negedge clk);
        check("midscan stays idle", 64'(out_ready), 64'd1);

        for (int i = 0; i < 50; i++) begin
            int col;
            int st;
            col = (($urandom % 8) == 0) ? 7 : int'($urandom_range(0, C - 1));
            st = (($urandom % 6) == 0) ? int'(($urandom % 2) * 3) : int'($urandom_range(1, 2));
            do_move(col, st, 1'($urandom), "random move");
            if (($urandom % 6) == 0) do_undo("random undo");
        end

        do_reset();
        b_exp_board = '0;
        b_exp_cells = '0;
        for (int c = 0; c < BC; c++) begin
            for (int r = 0; r < BR; r++) begin
                pst = int'($urandom_range(1, 2));
                b_move(c, pst, bd, be, bl);
                b_exp_board[r*BC+c] = 1'b1;
                b_exp_cells[r*BC+c] = (pst == 2);
                check("small fill done", 64'(bd), 64'd1);
                check("small fill latency", 64'(bl), 64'(r + 2));
                if (c == BC - 1 && r == BR - 2)
                    check("small not yet full", 64'(b_full), 64'd0);
            end
        end
        check("small board", 64'(b_board), 64'(b_exp_board));
        check("small cells", 64'(b_cells), 64'(b_exp_cells));
        check("small full", 64'(b_full), 64'd1);
        b_move(int'($urandom_range(0, BC - 1)), 1, bd, be, bl);
        check("small extra err", 64'(be), 64'd1);
        check("small extra latency", 64'(bl), 64'(BR + 1));
        check("small board kept", 64'(b_board), 64'(b_exp_board));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
